// File: rtl/pin_input_conditioner.sv
// pin_input_conditioner
// Cleans up raw asynchronous board pins (e.g. push-buttons) before they reach
// downstream logic. Each channel has a 2-FF synchronizer, a tick-sampled
// debouncer FSM and registered rise/fall edge pulses.
//
// Optional build macro: AUTOREPEAT_EN
//   When defined, a held-high level emits extra rise_pulse repeats, the first
//   REPEAT_DELAY ticks after the debounced rise, then every REPEAT_PERIOD ticks.
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   tick       sample enable for the debouncer (may be held high)
//   pin_in     raw asynchronous pins, one bit per channel
//   level_out  debounced level per channel
//   rise_pulse one-clk pulse on each debounced 0->1 (and each auto-repeat)
//   fall_pulse one-clk pulse on each debounced 1->0
//
// Debouncer states
//   STABLE  | synchronized pin agrees with level_out, nothing pending
//   CONFIRM | pin disagrees with level_out; cnt counts consecutive ticks of it
module pin_input_conditioner #(
  parameter int CH_COUNT       = 2,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_PERIOD  = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [CH_COUNT-1:0] pin_in,
  output logic [CH_COUNT-1:0] level_out,
  output logic [CH_COUNT-1:0] rise_pulse,
  output logic [CH_COUNT-1:0] fall_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  // cnt+1 == DEBOUNCE_TICKS is evaluated as cnt == DEBOUNCE_TICKS-1 so the
  // counter never needs an extra carry bit.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  if (DEBOUNCE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("pin_input_conditioner: DEBOUNCE_TICKS, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  typedef enum logic {
    STABLE  = 1'b0,
    CONFIRM = 1'b1
  } state_t;

  logic [CH_COUNT-1:0] sync_a;
  logic [CH_COUNT-1:0] sync_s;

  state_t           state     [CH_COUNT];
  state_t           state_nxt [CH_COUNT];
  logic [CNT_W-1:0] cnt       [CH_COUNT];
  logic [CNT_W-1:0] cnt_nxt   [CH_COUNT];

  logic [CH_COUNT-1:0] flip;
  logic [CH_COUNT-1:0] level_nxt;
  logic [CH_COUNT-1:0] rise_edge;
  logic [CH_COUNT-1:0] fall_edge;
  logic [CH_COUNT-1:0] rise_nxt;

  // Synchronizer runs every clk, independent of tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_s <= '0;
    end else begin
      sync_a <= pin_in;
      sync_s <= sync_a;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_COUNT; i++) begin
        state[i] <= STABLE;
        cnt[i]   <= '0;
      end
      level_out  <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
    end else begin
      for (int i = 0; i < CH_COUNT; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
      level_out  <= level_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_edge;
    end
  end

  always_comb begin
    for (int i = 0; i < CH_COUNT; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      flip[i]      = 1'b0;
      if (tick) begin
        case (state[i])
          STABLE: begin
            if (sync_s[i] != level_out[i]) begin
              if (DEBOUNCE_TICKS == 1) begin
                flip[i] = 1'b1;
              end else begin
                cnt_nxt[i]   = CNT_W'(1);
                state_nxt[i] = CONFIRM;
              end
            end
          end
          CONFIRM: begin
            if (sync_s[i] == level_out[i]) begin
              cnt_nxt[i]   = '0;
              state_nxt[i] = STABLE;
            end else if (cnt[i] == CNT_LAST) begin
              flip[i]      = 1'b1;
              cnt_nxt[i]   = '0;
              state_nxt[i] = STABLE;
            end else begin
              cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
          end
        endcase
      end
      level_nxt[i] = level_out[i] ^ flip[i];
      rise_edge[i] = flip[i] & ~level_out[i];
      fall_edge[i] = flip[i] & level_out[i];
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0]    rpt_cnt     [CH_COUNT];
  logic [RPT_W-1:0]    rpt_cnt_nxt [CH_COUNT];
  logic [CH_COUNT-1:0] rpt_first;
  logic [CH_COUNT-1:0] rpt_first_nxt;
  logic [CH_COUNT-1:0] rpt_fire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_COUNT; i++) begin
        rpt_cnt[i] <= '0;
      end
      rpt_first <= '0;
    end else begin
      for (int i = 0; i < CH_COUNT; i++) begin
        rpt_cnt[i] <= rpt_cnt_nxt[i];
      end
      rpt_first <= rpt_first_nxt;
    end
  end

  // rpt_first selects the initial delay vs. the steady repeat period. A tick
  // that also produces a fall never fires a repeat.
  always_comb begin
    for (int i = 0; i < CH_COUNT; i++) begin
      rpt_cnt_nxt[i]   = rpt_cnt[i];
      rpt_first_nxt[i] = rpt_first[i];
      rpt_fire[i]      = 1'b0;
      if (!level_out[i]) begin
        rpt_cnt_nxt[i]   = '0;
        rpt_first_nxt[i] = 1'b1;
      end else if (tick && !fall_edge[i]) begin
        if (rpt_cnt[i] == (rpt_first[i] ? DELAY_LAST : PERIOD_LAST)) begin
          rpt_fire[i]      = 1'b1;
          rpt_cnt_nxt[i]   = '0;
          rpt_first_nxt[i] = 1'b0;
        end else begin
          rpt_cnt_nxt[i] = rpt_cnt[i] + RPT_W'(1);
        end
      end
    end
    rise_nxt = rise_edge | rpt_fire;
  end
`else
  always_comb begin
    rise_nxt = rise_edge;
  end
`endif

endmodule

// File: tb/tb_pin_input_conditioner.sv
module tb_pin_input_conditioner;

  localparam int RD = 6;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [1:0] pin_in;
  logic [1:0] lv_a, rp_a, fp_a;
  logic [1:0] lv_b, rp_b, fp_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pin_input_conditioner #(
    .CH_COUNT(2), .DEBOUNCE_TICKS(4), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .pin_in(pin_in),
    .level_out(lv_a), .rise_pulse(rp_a), .fall_pulse(fp_a)
  );

  pin_input_conditioner #(
    .CH_COUNT(2), .DEBOUNCE_TICKS(3), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .pin_in(pin_in),
    .level_out(lv_b), .rise_pulse(rp_b), .fall_pulse(fp_b)
  );

  // Reference model, index [dut][channel]. Debounce is expressed as the run
  // length of consecutive tick samples that disagree with the current level.
  bit m_p1    [2][2];
  bit m_s     [2][2];
  bit m_lvl   [2][2];
  bit m_rise  [2][2];
  bit m_fall  [2][2];
  bit m_first [2][2];
  int m_run   [2][2];
  int m_since [2][2];

  function automatic int dt(int d);
    return (d == 0) ? 4 : 3;
  endfunction

  task automatic chk(string tag, logic [1:0] got, logic [1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_int(string tag, int got, int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(bit r, bit t, logic [1:0] p);
    bit s_old, l_old, flip;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        if (!r) begin
          m_p1[d][c] = 0; m_s[d][c] = 0; m_lvl[d][c] = 0;
          m_rise[d][c] = 0; m_fall[d][c] = 0; m_first[d][c] = 0;
          m_run[d][c] = 0; m_since[d][c] = 0;
        end else begin
          s_old = m_s[d][c];
          l_old = m_lvl[d][c];
          flip  = 0;
          m_s[d][c]    = m_p1[d][c];
          m_p1[d][c]   = p[c];
          m_rise[d][c] = 0;
          m_fall[d][c] = 0;
          if (t) begin
            if (s_old != l_old) begin
              m_run[d][c]++;
              if (m_run[d][c] == dt(d)) begin
                flip = 1;
                m_run[d][c] = 0;
              end
            end else begin
              m_run[d][c] = 0;
            end
            if (flip) begin
              m_lvl[d][c] = !l_old;
              if (l_old) m_fall[d][c] = 1;
              else begin
                m_rise[d][c]  = 1;
                m_since[d][c] = 0;
                m_first[d][c] = 1;
              end
            end
`ifdef AUTOREPEAT_EN
            else if (l_old) begin
              m_since[d][c]++;
              if (m_since[d][c] == (m_first[d][c] ? RD : RP)) begin
                m_rise[d][c]  = 1;
                m_since[d][c] = 0;
                m_first[d][c] = 0;
              end
            end
`endif
          end
        end
      end
    end
  endtask

  task automatic cyc();
    bit r, t;
    logic [1:0] p;
    r = rst_n; t = tick; p = pin_in;
    @(posedge clk);
    model_edge(r, t, p);
    #1;
    chk("lvl_a",  lv_a, {m_lvl[0][1],  m_lvl[0][0]});
    chk("rise_a", rp_a, {m_rise[0][1], m_rise[0][0]});
    chk("fall_a", fp_a, {m_fall[0][1], m_fall[0][0]});
    chk("lvl_b",  lv_b, {m_lvl[1][1],  m_lvl[1][0]});
    chk("rise_b", rp_b, {m_rise[1][1], m_rise[1][0]});
    chk("fall_b", fp_b, {m_fall[1][1], m_fall[1][0]});
  endtask

  task automatic settle();
    tick = 1'b1;
    pin_in = 2'b00;
    for (int k = 0; k < 10; k++) cyc();
  endtask

  initial begin
    int first_a, first_b, n_a, n_b, n_both, n_single, n_lvl_diff, fall_k, rise_after;
    int bad_ch0, run_len;
    logic [1:0] rp_at_first;
    int rise_q[$];
    int exp_q[$];

    // 1. reset with pins high, then release
    rst_n = 1'b0; tick = 1'b1; pin_in = 2'b11;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("reset_lvl", lv_a, 2'b00);
    end
    rst_n = 1'b1;
    first_a = 0; first_b = 0; n_a = 0; rp_at_first = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (rp_a != 2'b00) begin
        n_a++;
        if (first_a == 0) begin first_a = k; rp_at_first = rp_a; end
      end
      if (rp_b != 2'b00 && first_b == 0) first_b = k;
    end
    chk_int("t1_rise_clk_a", first_a, 6);
    chk_int("t1_rise_cnt_a", n_a, 1);
    chk("t1_rise_val_a", rp_at_first, 2'b11);
    chk_int("t1_rise_clk_b", first_b, 5);
    chk("t1_level_a", lv_a, 2'b11);

    // 2. bounce rejection on channel 0 (runs of at most 3 high samples)
    settle();
    bad_ch0 = 0;
    for (int rep = 0; rep < 12; rep++) begin
      run_len = (rep < 2) ? 3 : $urandom_range(1, 3);
      for (int k = 0; k < run_len; k++) begin
        pin_in = 2'b01;
        cyc();
        if (lv_a[0] || rp_a[0] || fp_a[0]) bad_ch0++;
      end
      pin_in = 2'b00;
      cyc();
      if (lv_a[0] || rp_a[0] || fp_a[0]) bad_ch0++;
    end
    chk_int("t2_bounce_a", bad_ch0, 0);

    // 3. slow tick (every 5th clk) on channel 1
    settle();
    pin_in = 2'b10;
    first_a = 0; first_b = 0; n_b = 0;
    for (int k = 0; k < 35; k++) begin
      tick = (k % 5 == 0);
      cyc();
      if (rp_b[1]) begin n_b++; if (first_b == 0) first_b = k; end
      if (rp_a[1] && first_a == 0) first_a = k;
    end
    chk_int("t3_rise_clk_b", first_b, 15);
    chk_int("t3_rise_cnt_b", n_b, 1);
    chk_int("t3_rise_clk_a", first_a, 20);
    pin_in = 2'b00;
    first_b = 0; n_b = 0;
    for (int k = 0; k < 35; k++) begin
      tick = (k % 5 == 0);
      cyc();
      if (fp_b[1]) begin n_b++; if (first_b == 0) first_b = k; end
    end
    chk_int("t3_fall_clk_b", first_b, 15);
    chk_int("t3_fall_cnt_b", n_b, 1);

    // 4. simultaneous rise on both channels
    settle();
    pin_in = 2'b11;
    n_both = 0; n_single = 0; n_lvl_diff = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (rp_a == 2'b11) n_both++;
      if (rp_a == 2'b01 || rp_a == 2'b10) n_single++;
      if (lv_a != 2'b00 && lv_a != 2'b11) n_lvl_diff++;
    end
    chk_int("t4_both", n_both, 1);
    chk_int("t4_single", n_single, 0);
    chk_int("t4_lvl_split", n_lvl_diff, 0);

    // 5. reset in the middle of a confirm
    settle();
    pin_in = 2'b01;
    for (int k = 0; k < 4; k++) cyc();
    rst_n = 1'b0;
    cyc();
    chk("t5_lvl_after_rst", lv_a, 2'b00);
    rst_n = 1'b1;
    first_a = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (rp_a[0] && first_a == 0) first_a = k;
    end
    chk_int("t5_rise_clk_a", first_a, 6);

    // 6. held pin: auto-repeat pattern (single rise when repeat is absent)
    settle();
    pin_in = 2'b01;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (rp_a[0]) rise_q.push_back(k);
    end
`ifdef AUTOREPEAT_EN
    exp_q = '{6, 12, 15, 18};
`else
    exp_q = '{6};
`endif
    chk_int("t6_rise_count", rise_q.size(), exp_q.size());
    for (int i = 0; i < rise_q.size() && i < exp_q.size(); i++)
      chk_int("t6_rise_clk", rise_q[i], exp_q[i]);
    pin_in = 2'b00;
    n_a = 0; fall_k = 0; rise_after = 0;
    for (int k = 1; k <= 14; k++) begin
      cyc();
      if (fp_a[0]) begin n_a++; fall_k = k; end
      if (rp_a[0] && fall_k != 0) rise_after++;
    end
    chk_int("t6_fall_count", n_a, 1);
    chk_int("t6_fall_clk", fall_k, 6);
    chk_int("t6_rise_after_fall", rise_after, 0);

    // random stimulus against the model
    for (int k = 0; k < 400; k++) begin
      tick = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) == 0) pin_in[0] = ~pin_in[0];
      if ($urandom_range(0, 9) == 0) pin_in[1] = ~pin_in[1];
      rst_n = ($urandom_range(0, 149) != 0);
      cyc();
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
